// File: rtl/intersection_scheduler_if.sv
// Signal bundle between the intersection scheduler and the controller that drives
// its requests and observes the signal heads.
interface intersection_scheduler_if;
  logic       i_start;
  logic [1:0] i_ped_req;
  logic [1:0] i_left_req;
  logic [3:0] o_car_a;
  logic [1:0] o_walk_a;
  logic [3:0] o_car_b;
  logic [1:0] o_walk_b;
  logic [3:0] o_phase;

  modport master (
    output i_start, i_ped_req, i_left_req,
    input  o_car_a, o_walk_a, o_car_b, o_walk_b, o_phase
  );

  modport slave (
    input  i_start, i_ped_req, i_left_req,
    output o_car_a, o_walk_a, o_car_b, o_walk_b, o_phase
  );
endinterface

// File: rtl/intersection_scheduler.sv
// Two-approach intersection scheduler: left/green/yellow/all-red phases for A then B,
// with latched pedestrian and left-turn requests served on the requester's next green.
module intersection_scheduler #(
  parameter int GREEN_T  = 8,
  parameter int LEFT_T   = 3,
  parameter int YELLOW_T = 2,
  parameter int ALLRED_T = 1,
  parameter int WALK_T   = 4,
  parameter int TIMER_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  intersection_scheduler_if.slave bus
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_A_LEFT   = 4'd1;
  localparam logic [3:0] S_A_GREEN  = 4'd2;
  localparam logic [3:0] S_A_YELLOW = 4'd3;
  localparam logic [3:0] S_A_ALLRED = 4'd4;
  localparam logic [3:0] S_B_LEFT   = 4'd5;
  localparam logic [3:0] S_B_GREEN  = 4'd6;
  localparam logic [3:0] S_B_YELLOW = 4'd7;
  localparam logic [3:0] S_B_ALLRED = 4'd8;

  localparam logic [TIMER_W-1:0] GREEN_LD  = TIMER_W'(GREEN_T - 1);
  localparam logic [TIMER_W-1:0] LEFT_LD   = TIMER_W'(LEFT_T - 1);
  localparam logic [TIMER_W-1:0] YELLOW_LD = TIMER_W'(YELLOW_T - 1);
  localparam logic [TIMER_W-1:0] ALLRED_LD = TIMER_W'(ALLRED_T - 1);

  logic [3:0]         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         left_pend_q, left_pend_d;
  logic [1:0]         ped_pend_q, ped_pend_d;
  logic [1:0]         walk_q, walk_d;

  logic advance;
  logic walk_window;
  logic [3:0] car_a, car_b;
  logic [1:0] walk_a, walk_b;

  // IDLE has no timed length; it leaves on the first enabled edge.
  assign advance = bus.i_start && ((state_q == S_IDLE) || (timer_q == '0));

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    left_pend_d = left_pend_q | bus.i_left_req;
    ped_pend_d  = ped_pend_q | bus.i_ped_req;
    walk_d      = walk_q;

    if (advance) begin
      case (state_q)
        S_IDLE, S_B_ALLRED:
          state_d = (left_pend_q[0] | bus.i_left_req[0]) ? S_A_LEFT : S_A_GREEN;
        S_A_LEFT:   state_d = S_A_GREEN;
        S_A_GREEN:  state_d = S_A_YELLOW;
        S_A_YELLOW: state_d = S_A_ALLRED;
        S_A_ALLRED:
          state_d = (left_pend_q[1] | bus.i_left_req[1]) ? S_B_LEFT : S_B_GREEN;
        S_B_LEFT:   state_d = S_B_GREEN;
        S_B_GREEN:  state_d = S_B_YELLOW;
        S_B_YELLOW: state_d = S_B_ALLRED;
        default:    state_d = S_IDLE;
      endcase

      case (state_d)
        S_A_LEFT, S_B_LEFT:     timer_d = LEFT_LD;
        S_A_GREEN, S_B_GREEN:   timer_d = GREEN_LD;
        S_A_YELLOW, S_B_YELLOW: timer_d = YELLOW_LD;
        S_A_ALLRED, S_B_ALLRED: timer_d = ALLRED_LD;
        default:                timer_d = '0;
      endcase

      // Entry into a left or green phase serves the matching request, including
      // one arriving on this very edge.
      case (state_d)
        S_A_LEFT: left_pend_d[0] = 1'b0;
        S_B_LEFT: left_pend_d[1] = 1'b0;
        S_A_GREEN: begin
          ped_pend_d[0] = 1'b0;
          walk_d[0]     = ped_pend_q[0] | bus.i_ped_req[0];
        end
        S_B_GREEN: begin
          ped_pend_d[1] = 1'b0;
          walk_d[1]     = ped_pend_q[1] | bus.i_ped_req[1];
        end
        default: ;
      endcase
    end else if (bus.i_start) begin
      timer_d = timer_q - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      left_pend_q <= '0;
      ped_pend_q  <= '0;
      walk_q      <= '0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      left_pend_q <= left_pend_d;
      ped_pend_q  <= ped_pend_d;
      walk_q      <= walk_d;
    end
  end

  // The timer counts down from GREEN_T-1, so the first WALK_T green cycles are
  // those whose timer value is at least GREEN_T-WALK_T.
  assign walk_window = int'(timer_q) >= (GREEN_T - WALK_T);

  always_comb begin
    car_a  = 4'b0001;
    car_b  = 4'b0001;
    walk_a = 2'b01;
    walk_b = 2'b01;
    case (state_q)
      S_A_LEFT:   car_a = 4'b1001;
      S_A_GREEN: begin
        car_a = 4'b0100;
        if (walk_q[0] && walk_window) walk_a = 2'b10;
      end
      S_A_YELLOW: car_a = 4'b0010;
      S_B_LEFT:   car_b = 4'b1001;
      S_B_GREEN: begin
        car_b = 4'b0100;
        if (walk_q[1] && walk_window) walk_b = 2'b10;
      end
      S_B_YELLOW: car_b = 4'b0010;
      default: ;
    endcase
  end

  assign bus.o_car_a  = car_a;
  assign bus.o_car_b  = car_b;
  assign bus.o_walk_a = walk_a;
  assign bus.o_walk_b = walk_b;
  assign bus.o_phase  = state_q;

endmodule

// File: tb/tb_intersection_scheduler.sv
// Directed self-checking bench for intersection_scheduler: phase sequence, requests,
// pause, reset and request-on-entry behaviour with hand-computed expectations.
module tb_intersection_scheduler;

  logic clk = 1'b0;
  logic reset_n;
  int checks   = 0;
  int failures = 0;

  // Expected phase/length tables with default parameters.
  localparam logic [3:0] BASE_PH  [6]  = '{4'd2, 4'd3, 4'd4, 4'd6, 4'd7, 4'd8};
  localparam int         BASE_LEN [6]  = '{8, 2, 1, 8, 2, 1};
  localparam logic [3:0] LEFT_PH  [11] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                                           4'd2, 4'd3, 4'd4, 4'd6};
  localparam int         LEFT_LEN [11] = '{8, 2, 1, 3, 8, 2, 1, 8, 2, 1, 1};

  intersection_scheduler_if bus ();

  intersection_scheduler dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] exp_car_a(input logic [3:0] ph);
    case (ph)
      4'd1:    return 4'b1001;
      4'd2:    return 4'b0100;
      4'd3:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  function automatic logic [3:0] exp_car_b(input logic [3:0] ph);
    case (ph)
      4'd5:    return 4'b1001;
      4'd6:    return 4'b0100;
      4'd7:    return 4'b0010;
      default: return 4'b0001;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset_n        = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_ped_req  = 2'b00;
    bus.i_left_req = 2'b00;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.o_phase !== 4'd0) begin
        failures++;
        $display("FAIL reset_phase cyc=%0d got=%0d exp=0", i, bus.o_phase);
      end
      checks++;
      if ({bus.o_car_a, bus.o_car_b, bus.o_walk_a, bus.o_walk_b} !== 12'b0001_0001_01_01) begin
        failures++;
        $display("FAIL reset_heads cyc=%0d got=%b_%b_%b_%b exp=0001_0001_01_01",
                 i, bus.o_car_a, bus.o_car_b, bus.o_walk_a, bus.o_walk_b);
      end
      step();
    end
  endtask

  task automatic test_basic_sequence();
    int cyc = 0;
    apply_reset();
    bus.i_start = 1'b1;
    checks++;
    if (bus.o_phase !== 4'd0) begin
      failures++;
      $display("FAIL basic_idle got=%0d exp=0", bus.o_phase);
    end
    for (int rep = 0; rep < 2; rep++) begin
      for (int s = 0; s < 6; s++) begin
        for (int k = 0; k < BASE_LEN[s]; k++) begin
          step();
          cyc++;
          checks++;
          if (bus.o_phase !== BASE_PH[s]) begin
            failures++;
            $display("FAIL basic_phase cyc=%0d got=%0d exp=%0d", cyc, bus.o_phase, BASE_PH[s]);
          end
          checks++;
          if (bus.o_car_a !== exp_car_a(BASE_PH[s]) || bus.o_car_b !== exp_car_b(BASE_PH[s]) ||
              bus.o_walk_a !== 2'b01 || bus.o_walk_b !== 2'b01) begin
            failures++;
            $display("FAIL basic_heads cyc=%0d got=%b_%b_%b_%b exp=%b_%b_01_01", cyc,
                     bus.o_car_a, bus.o_car_b, bus.o_walk_a, bus.o_walk_b,
                     exp_car_a(BASE_PH[s]), exp_car_b(BASE_PH[s]));
          end
        end
      end
    end
  endtask

  task automatic test_ped_request();
    logic [1:0] exp_walk;
    apply_reset();
    bus.i_start = 1'b1;
    for (int cyc = 1; cyc <= 52; cyc++) begin
      bus.i_ped_req = (cyc == 13) ? 2'b01 : 2'b00;
      step();
      if (cyc == 12 || cyc == 23 || cyc == 45) begin
        checks++;
        if (bus.o_phase !== ((cyc == 12) ? 4'd6 : 4'd2)) begin
          failures++;
          $display("FAIL ped_anchor cyc=%0d got=%0d", cyc, bus.o_phase);
        end
      end
      if (cyc >= 13) begin
        exp_walk = (cyc >= 23 && cyc <= 26) ? 2'b10 : 2'b01;
        checks++;
        if (bus.o_walk_a !== exp_walk || bus.o_walk_b !== 2'b01) begin
          failures++;
          $display("FAIL ped_walk cyc=%0d got_a=%b got_b=%b exp_a=%b exp_b=01",
                   cyc, bus.o_walk_a, bus.o_walk_b, exp_walk);
        end
      end
    end
    bus.i_ped_req = 2'b00;
  endtask

  task automatic test_left_request();
    int cyc = 0;
    apply_reset();
    bus.i_start = 1'b1;
    for (int s = 0; s < 11; s++) begin
      for (int k = 0; k < LEFT_LEN[s]; k++) begin
        cyc++;
        bus.i_left_req = (cyc == 2) ? 2'b10 : 2'b00;
        step();
        checks++;
        if (bus.o_phase !== LEFT_PH[s]) begin
          failures++;
          $display("FAIL left_phase cyc=%0d got=%0d exp=%0d", cyc, bus.o_phase, LEFT_PH[s]);
        end
        if (LEFT_PH[s] == 4'd5) begin
          checks++;
          if (bus.o_car_b !== 4'b1001 || bus.o_car_a !== 4'b0001) begin
            failures++;
            $display("FAIL left_heads cyc=%0d got_a=%b got_b=%b exp_a=0001 exp_b=1001",
                     cyc, bus.o_car_a, bus.o_car_b);
          end
        end
      end
    end
    bus.i_left_req = 2'b00;
  endtask

  task automatic test_pause();
    logic [3:0] exp_ph;
    logic [1:0] exp_wb;
    apply_reset();
    for (int cyc = 1; cyc <= 25; cyc++) begin
      bus.i_start   = !(cyc == 5 || cyc == 6);
      bus.i_ped_req = (cyc == 5) ? 2'b10 : 2'b00;
      step();
      if (cyc <= 10)      exp_ph = 4'd2;
      else if (cyc <= 12) exp_ph = 4'd3;
      else if (cyc == 13) exp_ph = 4'd4;
      else if (cyc <= 21) exp_ph = 4'd6;
      else if (cyc <= 23) exp_ph = 4'd7;
      else if (cyc == 24) exp_ph = 4'd8;
      else                exp_ph = 4'd2;
      exp_wb = (cyc >= 14 && cyc <= 17) ? 2'b10 : 2'b01;
      checks++;
      if (bus.o_phase !== exp_ph) begin
        failures++;
        $display("FAIL pause_phase cyc=%0d got=%0d exp=%0d", cyc, bus.o_phase, exp_ph);
      end
      checks++;
      if (bus.o_walk_b !== exp_wb || bus.o_walk_a !== 2'b01) begin
        failures++;
        $display("FAIL pause_walk cyc=%0d got_a=%b got_b=%b exp_a=01 exp_b=%b",
                 cyc, bus.o_walk_a, bus.o_walk_b, exp_wb);
      end
    end
    bus.i_start   = 1'b1;
    bus.i_ped_req = 2'b00;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.i_start = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      bus.i_ped_req = (cyc == 13) ? 2'b01 : 2'b00;
      step();
    end
    checks++;
    if (bus.o_phase !== 4'd7) begin
      failures++;
      $display("FAIL rstmid_pre got=%0d exp=7", bus.o_phase);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if (bus.o_phase !== 4'd0 ||
        {bus.o_car_a, bus.o_car_b, bus.o_walk_a, bus.o_walk_b} !== 12'b0001_0001_01_01) begin
      failures++;
      $display("FAIL rstmid_idle got_ph=%0d heads=%b_%b_%b_%b exp_ph=0 heads=0001_0001_01_01",
               bus.o_phase, bus.o_car_a, bus.o_car_b, bus.o_walk_a, bus.o_walk_b);
    end
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (bus.o_phase !== 4'd2 || bus.o_walk_a !== 2'b01) begin
        failures++;
        $display("FAIL rstmid_green k=%0d got_ph=%0d got_walk=%b exp_ph=2 exp_walk=01",
                 k, bus.o_phase, bus.o_walk_a);
      end
    end
  endtask

  task automatic test_entry_request();
    logic [1:0] exp_walk;
    apply_reset();
    bus.i_start = 1'b1;
    for (int cyc = 1; cyc <= 67; cyc++) begin
      bus.i_ped_req = (cyc == 1 || cyc == 45) ? 2'b01 : 2'b00;
      step();
      if (cyc == 1 || cyc == 23 || cyc == 45 || cyc == 67) begin
        checks++;
        if (bus.o_phase !== 4'd2) begin
          failures++;
          $display("FAIL entry_anchor cyc=%0d got=%0d exp=2", cyc, bus.o_phase);
        end
      end
      exp_walk = ((cyc >= 1 && cyc <= 4) || (cyc >= 45 && cyc <= 48)) ? 2'b10 : 2'b01;
      checks++;
      if (bus.o_walk_a !== exp_walk) begin
        failures++;
        $display("FAIL entry_walk cyc=%0d got=%b exp=%b", cyc, bus.o_walk_a, exp_walk);
      end
    end
    bus.i_ped_req = 2'b00;
  endtask

  initial begin
    reset_n        = 1'b0;
    bus.i_start    = 1'b0;
    bus.i_ped_req  = 2'b00;
    bus.i_left_req = 2'b00;
    test_reset();
    test_basic_sequence();
    test_ped_request();
    test_left_request();
    test_pause();
    test_reset_mid();
    test_entry_request();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
